kypd_keypad_emulator: RTL and testbench

//  Responder end of the PmodKYPD scan interface: emulates the 4x4 keypad for hardware loopback and sim of the scanner.

---
 rtl/kypd_pkg.sv | 66 ++++++
 rtl/kypd_bounce_gen.sv | 130 +++++++++++++
 rtl/kypd_keypad_emulator.sv | 98 +++++++++
 tb/tb_kypd_keypad_emulator.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kypd_pkg.sv
// Shared constants, FSM state type and key index/label helpers for the
// PmodKYPD keypad emulator.
package kypd_pkg;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int KEYS  = ROWS * COLS;
  localparam int KEY_W = $clog2(KEYS);

  // Command sequencer states: waiting, injecting contact bounce, settling
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } kypd_emu_state_t;

  // Key index (row*4+col) to the ASCII legend printed on the keypad
  function automatic logic [7:0] key_label(input logic [KEY_W-1:0] idx);
    logic [7:0] lbl;
    case (idx)
      4'd0:    lbl = "1";
      4'd1:    lbl = "2";
      4'd2:    lbl = "3";
      4'd3:    lbl = "A";
      4'd4:    lbl = "4";
      4'd5:    lbl = "5";
      4'd6:    lbl = "6";
      4'd7:    lbl = "B";
      4'd8:    lbl = "7";
      4'd9:    lbl = "8";
      4'd10:   lbl = "9";
      4'd11:   lbl = "C";
      4'd12:   lbl = "0";
      4'd13:   lbl = "F";
      4'd14:   lbl = "E";
      default: lbl = "D";
    endcase
    return lbl;
  endfunction

  // ASCII legend back to key index; unknown legends map to key 0
  function automatic logic [KEY_W-1:0] key_index(input logic [7:0] lbl);
    logic [KEY_W-1:0] idx;
    case (lbl)
      "1":     idx = 4'd0;
      "2":     idx = 4'd1;
      "3":     idx = 4'd2;
      "A":     idx = 4'd3;
      "4":     idx = 4'd4;
      "5":     idx = 4'd5;
      "6":     idx = 4'd6;
      "B":     idx = 4'd7;
      "7":     idx = 4'd8;
      "8":     idx = 4'd9;
      "9":     idx = 4'd10;
      "C":     idx = 4'd11;
      "0":     idx = 4'd12;
      "F":     idx = 4'd13;
      "E":     idx = 4'd14;
      "D":     idx = 4'd15;
      default: idx = 4'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/kypd_bounce_gen.sv
// Command sequencer: accepts press/release commands, then replays the
// transition as a burst of contact-bounce toggles followed by a quiet
// settle window. Emits single-cycle key_set strobes toward the key register.
module kypd_bounce_gen
  import kypd_pkg::*;
#(
  parameter int BOUNCE_CNT    = 3,
  parameter int BOUNCE_PERIOD = 1000,
  parameter int SETTLE_CYC    = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [KEY_W-1:0] cmd_key,
  input  logic             cmd_press,
  input  logic             key_cur,
  output logic             key_set,
  output logic [KEY_W-1:0] key_idx,
  output logic             key_val,
  output logic             busy
);

  localparam int TOG_MAX = 2 * BOUNCE_CNT;
  localparam int PER_W   = $clog2(BOUNCE_PERIOD + 1);
  localparam int SET_W   = $clog2(SETTLE_CYC + 1);
  localparam int TOG_W   = (TOG_MAX < 1) ? 1 : $clog2(TOG_MAX + 1);

  // Terminal counts; a phase lasts exactly N cycles when counting 0..N-1
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(BOUNCE_PERIOD - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'((TOG_MAX > 0) ? TOG_MAX - 1 : 0);

  kypd_emu_state_t  state_reg, state_next;
  logic [KEY_W-1:0] key_reg, key_next;
  logic             tgt_reg, tgt_next;
  logic [PER_W-1:0] per_cnt_reg, per_cnt_next;
  logic [TOG_W-1:0] tog_cnt_reg, tog_cnt_next;
  logic [SET_W-1:0] set_cnt_reg, set_cnt_next;
  logic             transfer;

  assign cmd_ready = (state_reg == IDLE) & ~rst;
  assign busy      = (state_reg != IDLE);
  assign transfer  = cmd_valid & cmd_ready;

  // State and counter registers; reset aborts any bounce or settle in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      key_reg     <= '0;
      tgt_reg     <= 1'b0;
      per_cnt_reg <= '0;
      tog_cnt_reg <= '0;
      set_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      key_reg     <= key_next;
      tgt_reg     <= tgt_next;
      per_cnt_reg <= per_cnt_next;
      tog_cnt_reg <= tog_cnt_next;
      set_cnt_reg <= set_cnt_next;
    end
  end

  // Next-state, counter updates and key strobes
  always_comb begin
    state_next   = state_reg;
    key_next     = key_reg;
    tgt_next     = tgt_reg;
    per_cnt_next = per_cnt_reg;
    tog_cnt_next = tog_cnt_reg;
    set_cnt_next = set_cnt_reg;
    key_set      = 1'b0;
    key_idx      = key_reg;
    key_val      = tgt_reg;

    case (state_reg)
      IDLE: begin
        if (transfer) begin
          // First edge lands immediately; counters start fresh for the next phase
          key_next     = cmd_key;
          tgt_next     = cmd_press;
          key_set      = 1'b1;
          key_idx      = cmd_key;
          key_val      = cmd_press;
          per_cnt_next = '0;
          tog_cnt_next = '0;
          set_cnt_next = '0;
          // A redundant command produces no edge, hence nothing to bounce
          if ((key_cur == cmd_press) || (BOUNCE_CNT == 0)) begin
            state_next = SETTLE;
          end else begin
            state_next = BOUNCE;
          end
        end
      end

      BOUNCE: begin
        if (per_cnt_reg == PER_LAST) begin
          per_cnt_next = '0;
          key_set      = 1'b1;
          // Odd-numbered toggles leave the contact opposite to the target,
          // so the even final toggle lands back on the target level
          key_val      = tgt_reg ^ ~tog_cnt_reg[0];
          if (tog_cnt_reg == TOG_LAST) begin
            state_next   = SETTLE;
            set_cnt_next = '0;
          end else begin
            tog_cnt_next = tog_cnt_reg + TOG_W'(1);
          end
        end else begin
          per_cnt_next = per_cnt_reg + PER_W'(1);
        end
      end

      SETTLE: begin
        if (set_cnt_reg == SET_LAST) begin
          state_next = IDLE;
        end else begin
          set_cnt_next = set_cnt_reg + SET_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/kypd_keypad_emulator.sv
// PmodKYPD responder: looks like a passive 4x4 key matrix to a column
// scanner. Columns are synchronised, rows are decoded from the emulated
// contacts and optionally delayed to model slow wiring.
module kypd_keypad_emulator
  import kypd_pkg::*;
#(
  parameter int RESP_DLY      = 0,
  parameter int BOUNCE_CNT    = 3,
  parameter int BOUNCE_PERIOD = 1000,
  parameter int SETTLE_CYC    = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [COLS-1:0]  col_n,
  output logic [ROWS-1:0]  row_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [KEY_W-1:0] cmd_key,
  input  logic             cmd_press,
  output logic [KEYS-1:0]  key_state,
  output logic             busy
);

  logic [COLS-1:0]              col_meta_reg;
  logic [COLS-1:0]              col_s_reg;
  logic [KEYS-1:0]              key_state_reg;
  logic [ROWS-1:0]              row_c;
  logic [RESP_DLY:0][ROWS-1:0]  row_pipe_reg;
  logic                         key_set;
  logic [KEY_W-1:0]             key_idx;
  logic                         key_val;
  logic                         key_cur;

  // Two-flop synchroniser for the scanner's asynchronous column drive;
  // resets to "no column driven" so rows stay released
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_reg <= '1;
      col_s_reg    <= '1;
    end else begin
      col_meta_reg <= col_n;
      col_s_reg    <= col_meta_reg;
    end
  end

  // Contact level of the addressed key, used to spot redundant commands
  assign key_cur = key_state_reg[cmd_key];

  kypd_bounce_gen #(
    .BOUNCE_CNT    (BOUNCE_CNT),
    .BOUNCE_PERIOD (BOUNCE_PERIOD),
    .SETTLE_CYC    (SETTLE_CYC)
  ) u_bounce_gen (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_key   (cmd_key),
    .cmd_press (cmd_press),
    .key_cur   (key_cur),
    .key_set   (key_set),
    .key_idx   (key_idx),
    .key_val   (key_val),
    .busy      (busy)
  );

  // Emulated contacts; only the key addressed by the sequencer ever changes
  always_ff @(posedge clk) begin
    if (rst) begin
      key_state_reg <= '0;
    end else if (key_set) begin
      key_state_reg[key_idx] <= key_val;
    end
  end

  assign key_state = key_state_reg;

  // A row is pulled low when any closed key on it sits in a driven column;
  // ideal diodes, so no ghost paths through neighbouring keys
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign row_c[gi] = |(key_state_reg[gi*COLS +: COLS] & ~col_s_reg);
  end

  // Registered row output followed by RESP_DLY extra wiring-delay stages
  always_ff @(posedge clk) begin
    if (rst) begin
      row_pipe_reg <= '1;
    end else begin
      row_pipe_reg[0] <= ~row_c;
      for (int i = 1; i <= RESP_DLY; i++) begin
        row_pipe_reg[i] <= row_pipe_reg[i-1];
      end
    end
  end

  assign row_n = row_pipe_reg[RESP_DLY];

endmodule

// File: tb/tb_kypd_keypad_emulator.sv
// Bench for the keypad emulator. Three instances with different bounce and
// delay settings are each tracked by a timeline model built from the
// command rules (edge times, toggle counts, settle windows).
module tb_kypd_keypad_emulator;

  localparam int P    = 4;
  localparam int S    = 8;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_v   = 3'b111;
  logic [2:0]  valid_v = 3'b000;
  logic [2:0]  press_v = 3'b000;
  logic [2:0]  rdy_o;
  logic [2:0]  busy_o;
  logic [3:0]  col_v [3];
  logic [3:0]  key_v [3];
  logic [3:0]  row_o [3];
  logic [15:0] ks_o  [3];

  // inst0: bounce 2, no delay; inst1: clean edges; inst2: bounce 2, 3-stage delay
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    kypd_keypad_emulator #(
      .RESP_DLY      ((gi == 2) ? 3 : 0),
      .BOUNCE_CNT    ((gi == 1) ? 0 : 2),
      .BOUNCE_PERIOD (P),
      .SETTLE_CYC    (S)
    ) u_dut (
      .clk       (clk),
      .rst       (rst_v[gi]),
      .col_n     (col_v[gi]),
      .row_n     (row_o[gi]),
      .cmd_valid (valid_v[gi]),
      .cmd_ready (rdy_o[gi]),
      .cmd_key   (key_v[gi]),
      .cmd_press (press_v[gi]),
      .key_state (ks_o[gi]),
      .busy      (busy_o[gi])
    );
  end

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state
  logic [15:0] m_ks [3];
  int          ready_at [3];
  int          last_rst [3];
  int          start [3];
  int          m_key [3];
  logic        m_t [3];
  bit          act [3];
  bit          acc [3];
  logic [3:0]  col_hist [3][MAXC];
  logic [15:0] ks_hist  [3][MAXC];

  function automatic int bcnt(input int i);
    return (i == 1) ? 0 : 2;
  endfunction

  function automatic int rdly(input int i);
    return (i == 2) ? 3 : 0;
  endfunction

  // Rows after edge m: contacts one edge earlier, columns two edges earlier
  // (synchroniser), everything shifted by the extra delay stages
  function automatic logic [3:0] exp_row(input int i, input int m);
    int q;
    logic [15:0] ks;
    logic [3:0] col;
    logic [3:0] rc;
    q = m - rdly(i);
    if (q <= last_rst[i]) return 4'hF;
    ks = ks_hist[i][q-1];
    col = col_hist[i][q-2];
    rc = 4'h0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (ks[r*4+c] && !col[c]) rc[r] = 1'b1;
    return ~rc;
  endfunction

  // Model the effect of clock edge n given the inputs presented now
  task automatic model_edge(input int i, input int n);
    int d, tg;
    bit ready_before, bnc;
    acc[i] = 1'b0;
    ready_before = ((n - 1) >= ready_at[i]);
    if (rst_v[i]) begin
      m_ks[i] = 16'h0;
      ready_at[i] = n;
      last_rst[i] = n;
      act[i] = 1'b0;
      col_hist[i][n] = 4'hF;
      col_hist[i][n-1] = 4'hF;
    end else begin
      if (act[i]) begin
        d = n - start[i];
        tg = d / P;
        if (tg > 2 * bcnt(i)) tg = 2 * bcnt(i);
        m_ks[i][m_key[i]] = m_t[i] ^ tg[0];
      end
      if (valid_v[i] && ready_before) begin
        bnc = (m_ks[i][key_v[i]] != press_v[i]) && (bcnt(i) > 0);
        m_ks[i][key_v[i]] = press_v[i];
        m_key[i] = int'(key_v[i]);
        m_t[i] = press_v[i];
        start[i] = n;
        act[i] = bnc;
        ready_at[i] = n + (bnc ? 2 * bcnt(i) * P : 0) + S;
        acc[i] = 1'b1;
      end
      col_hist[i][n] = col_v[i];
    end
    ks_hist[i][n] = m_ks[i];
  endtask

  // Advance one clock: update the model, then land on the falling edge
  task automatic tick();
    if (cyc + 2 >= MAXC) begin
      $display("FAIL cycle_budget: cyc=%0d required below %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    for (int i = 0; i < 3; i++) model_edge(i, cyc + 1);
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_cmd(input int i, input int k, input bit p);
    valid_v[i] = 1'b1;
    key_v[i] = 4'(k);
    press_v[i] = p;
    for (int j = 0; j < 200; j++) begin
      tick();
      if (acc[i]) break;
    end
    valid_v[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    for (int j = 0; j < 200 && cyc < ready_at[i]; j++) tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) col_v[i] = 4'h0;
    rst_v = 3'b111;
    repeat (3) tick();
    rst_v = 3'b000;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (row_o[i] !== 4'hF) begin n_fail++; $display("FAIL reset_row inst%0d: got %h want f", i, row_o[i]); end
      n_run++;
      if (ks_o[i] !== 16'h0) begin n_fail++; $display("FAIL reset_keys inst%0d: got %h want 0000", i, ks_o[i]); end
      n_run++;
      if (rdy_o[i] !== 1'b1) begin n_fail++; $display("FAIL reset_ready inst%0d: got %b want 1", i, rdy_o[i]); end
      n_run++;
      if (busy_o[i] !== 1'b0) begin n_fail++; $display("FAIL reset_busy inst%0d: got %b want 0", i, busy_o[i]); end
      n_run++;
    end
    for (int i = 0; i < 3; i++) col_v[i] = 4'hF;
    tick();
  endtask

  // Clean edge: key '6' (index 6, row 1 col 2) against single-column scans
  task automatic test_clean_press();
    logic [3:0] want;
    send_cmd(1, 6, 1'b1);
    if (ks_o[1] !== 16'h0040) begin n_fail++; $display("FAIL clean_keys: got %h want 0040", ks_o[1]); end
    n_run++;
    if (rdy_o[1] !== 1'b0) begin n_fail++; $display("FAIL clean_ready_low: got %b want 0", rdy_o[1]); end
    n_run++;
    wait_idle(1);
    if (rdy_o[1] !== 1'b1) begin n_fail++; $display("FAIL clean_ready_back: got %b want 1", rdy_o[1]); end
    n_run++;
    col_v[1] = 4'b1011;
    for (int t = 1; t <= 3; t++) begin
      tick();
      want = (t == 3) ? 4'b1101 : 4'hF;
      if (row_o[1] !== want) begin n_fail++; $display("FAIL clean_col2 t=%0d: got %b want %b", t, row_o[1], want); end
      n_run++;
    end
    col_v[1] = 4'b1110;
    for (int t = 1; t <= 3; t++) begin
      tick();
      want = (t == 3) ? 4'hF : 4'b1101;
      if (row_o[1] !== want) begin n_fail++; $display("FAIL clean_col0 t=%0d: got %b want %b", t, row_o[1], want); end
      n_run++;
    end
    send_cmd(1, 6, 1'b0);
    wait_idle(1);
  endtask

  // Keys '1' and '0' share column 0; extra driven columns add nothing
  task automatic test_multi_key();
    send_cmd(1, 0, 1'b1);
    wait_idle(1);
    send_cmd(1, 12, 1'b1);
    wait_idle(1);
    col_v[1] = 4'b1110;
    repeat (3) tick();
    if (row_o[1] !== 4'b0110) begin n_fail++; $display("FAIL multi_col0: got %b want 0110", row_o[1]); end
    n_run++;
    col_v[1] = 4'b0000;
    repeat (3) tick();
    if (row_o[1] !== 4'b0110) begin n_fail++; $display("FAIL multi_allcols: got %b want 0110", row_o[1]); end
    n_run++;
    send_cmd(1, 0, 1'b0);
    tick();
    if (row_o[1] !== 4'b0111) begin n_fail++; $display("FAIL multi_release: got %b want 0111", row_o[1]); end
    n_run++;
    if (ks_o[1] !== 16'h1000) begin n_fail++; $display("FAIL multi_keys: got %h want 1000", ks_o[1]); end
    n_run++;
    wait_idle(1);
    col_v[1] = 4'hF;
  endtask

  // Bounce: contact reads 1,0,1,0,1 in 4-clock steps, ready 8 clocks after last edge
  task automatic test_bounce();
    logic want_k, want_r;
    valid_v[0] = 1'b1;
    key_v[0] = 4'd0;
    press_v[0] = 1'b1;
    tick();
    valid_v[0] = 1'b0;
    for (int d = 0; d <= 25; d++) begin
      want_k = (d >= 16) ? 1'b1 : (((d / 4) % 2) == 0);
      want_r = (d >= 24);
      if (ks_o[0][0] !== want_k) begin n_fail++; $display("FAIL bounce_level d=%0d: got %b want %b", d, ks_o[0][0], want_k); end
      n_run++;
      if (rdy_o[0] !== want_r) begin n_fail++; $display("FAIL bounce_ready d=%0d: got %b want %b", d, rdy_o[0], want_r); end
      n_run++;
      tick();
    end
  endtask

  // A command held during another key's bounce waits for IDLE
  task automatic test_hold_other();
    logic want;
    send_cmd(0, 3, 1'b1);
    valid_v[0] = 1'b1;
    key_v[0] = 4'd7;
    press_v[0] = 1'b1;
    for (int d = 1; d <= 25; d++) begin
      tick();
      want = (d == 25);
      if (ks_o[0][7] !== want) begin n_fail++; $display("FAIL hold_key7 d=%0d: got %b want %b", d, ks_o[0][7], want); end
      n_run++;
      if (ks_o[0] !== m_ks[0]) begin n_fail++; $display("FAIL hold_keys d=%0d: got %h want %h", d, ks_o[0], m_ks[0]); end
      n_run++;
    end
    valid_v[0] = 1'b0;
  endtask

  // Reset in the middle of a bounce burst
  task automatic test_reset_mid();
    wait_idle(0);
    col_v[0] = 4'h0;
    send_cmd(0, 9, 1'b1);
    repeat (6) tick();
    rst_v[0] = 1'b1;
    tick();
    if (ks_o[0] !== 16'h0) begin n_fail++; $display("FAIL rstmid_keys: got %h want 0000", ks_o[0]); end
    n_run++;
    if (row_o[0] !== 4'hF) begin n_fail++; $display("FAIL rstmid_row: got %b want 1111", row_o[0]); end
    n_run++;
    if (busy_o[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy_o[0]); end
    n_run++;
    rst_v[0] = 1'b0;
    #1;
    if (rdy_o[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", rdy_o[0]); end
    n_run++;
    col_v[0] = 4'hF;
    tick();
  endtask

  // Three delay stages: column change reaches the row pins after 6 clocks
  task automatic test_resp_dly();
    logic [3:0] want;
    send_cmd(2, 6, 1'b1);
    wait_idle(2);
    repeat (3) tick();
    col_v[2] = 4'b1011;
    for (int t = 1; t <= 7; t++) begin
      tick();
      want = (t >= 6) ? 4'b1101 : 4'hF;
      if (row_o[2] !== want) begin n_fail++; $display("FAIL dly_row t=%0d: got %b want %b", t, row_o[2], want); end
      n_run++;
    end
    col_v[2] = 4'hF;
  endtask

  // Random commands, column scans and occasional resets on all instances
  task automatic test_random();
    logic [3:0] want_row;
    logic want_rdy;
    for (int it = 0; it < 500; it++) begin
      for (int i = 0; i < 3; i++) begin
        if (!valid_v[i] && $urandom_range(0, 3) == 0) begin
          valid_v[i] = 1'b1;
          key_v[i] = 4'($urandom_range(0, 15));
          press_v[i] = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 7) == 0) col_v[i] = 4'($urandom);
        rst_v[i] = ($urandom_range(0, 149) == 0);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        if (acc[i]) valid_v[i] = 1'b0;
        want_row = exp_row(i, cyc);
        want_rdy = (cyc >= ready_at[i]) && !rst_v[i];
        if (ks_o[i] !== m_ks[i]) begin n_fail++; $display("FAIL rand_keys inst%0d cyc%0d: got %h want %h", i, cyc, ks_o[i], m_ks[i]); end
        n_run++;
        if (row_o[i] !== want_row) begin n_fail++; $display("FAIL rand_row inst%0d cyc%0d: got %b want %b", i, cyc, row_o[i], want_row); end
        n_run++;
        if (rdy_o[i] !== want_rdy) begin n_fail++; $display("FAIL rand_ready inst%0d cyc%0d: got %b want %b", i, cyc, rdy_o[i], want_rdy); end
        n_run++;
        if (busy_o[i] !== (cyc < ready_at[i])) begin n_fail++; $display("FAIL rand_busy inst%0d cyc%0d: got %b want %b", i, cyc, busy_o[i], (cyc < ready_at[i])); end
        n_run++;
      end
    end
    rst_v = 3'b000;
    valid_v = 3'b000;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      col_v[i] = 4'h0;
      key_v[i] = 4'h0;
      m_ks[i] = 16'h0;
      ready_at[i] = 0;
      last_rst[i] = 0;
      start[i] = 0;
      m_key[i] = 0;
      m_t[i] = 1'b0;
      act[i] = 1'b0;
      acc[i] = 1'b0;
    end
    test_reset();
    test_clean_press();
    test_multi_key();
    test_bounce();
    test_hold_other();
    test_reset_mid();
    test_resp_dly();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
